// File: rtl/trng_sample_collector.sv
// trng_sample_collector
//   Consumer for the FiRO3 ring-oscillator entropy source. Enables the
//   oscillator, discards a warm-up run of samples, then runs continuous
//   repetition-count (RCT) and adaptive-proportion (APT) health tests while
//   packing samples LSB-first into words for the SHA3 conditioner.
//
// Ports
//   clk          single clock
//   rst_n        synchronous active-low reset
//   enable       request entropy collection
//   raw_bit      oscillator random_out
//   osc_en       oscillator en
//   dff_en       oscillator dff_en
//   word_out     packed word (bit i = i-th sample of the word)
//   word_valid   word_out holds an unconsumed word
//   word_ready   conditioner accepts the word
//   health_fail  sticky health-test failure
//   clear_fail   clear failure, return to IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | oscillator off, waiting for enable
// S_WARMUP  | oscillator on, discarding the first WARMUP samples
// S_COLLECT | packing samples and running RCT/APT on each one
// S_FAIL    | health test tripped, oscillator off until clear_fail

module trng_sample_collector #(
   parameter int WORD_W     = 64,
   parameter int WARMUP     = 256,
   parameter int RCT_CUTOFF = 32,
   parameter int APT_WINDOW = 512,
   parameter int APT_CUTOFF = 410
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              raw_bit,
   output logic              osc_en,
   output logic              dff_en,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              health_fail,
   input  logic              clear_fail
);

   localparam int WU_W = $clog2(WARMUP + 1);
   localparam int BC_W = $clog2(WORD_W + 1);
   localparam int RC_W = $clog2(RCT_CUTOFF + 1);
   localparam int AP_W = $clog2(APT_WINDOW + 1);

   localparam logic [WU_W-1:0] WARM_LOAD = WU_W'(WARMUP - 1);
   localparam logic [BC_W-1:0] BIT_LOAD  = BC_W'(WORD_W - 1);
   localparam logic [AP_W-1:0] WIN_LOAD  = AP_W'(APT_WINDOW - 1);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_FAIL} state_t;

   state_t            state, state_nxt;
   logic              smp_v;
   logic [WU_W-1:0]   warm_left, warm_left_nxt;
   logic [BC_W-1:0]   bit_left, bit_left_nxt;
   logic [WORD_W-1:0] shreg, shreg_nxt, word_out_nxt, word_new;
   logic              word_valid_nxt, health_fail_nxt;
   logic              rct_last, rct_last_nxt;
   logic [RC_W-1:0]   rct_run, rct_run_nxt;
   logic              apt_ref, apt_ref_nxt;
   logic [AP_W-1:0]   apt_cnt, apt_cnt_nxt;
   logic [AP_W-1:0]   apt_left, apt_left_nxt;
   logic              consume, fail;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      warm_left_nxt   = warm_left;
      bit_left_nxt    = bit_left;
      shreg_nxt       = shreg;
      word_out_nxt    = word_out;
      word_valid_nxt  = word_valid;
      health_fail_nxt = health_fail;
      rct_last_nxt    = rct_last;
      rct_run_nxt     = rct_run;
      apt_ref_nxt     = apt_ref;
      apt_cnt_nxt     = apt_cnt;
      apt_left_nxt    = apt_left;
      fail            = 1'b0;
      consume         = smp_v && (state == S_WARMUP || state == S_COLLECT);
      word_new        = {raw_bit, shreg[WORD_W-1:1]};

      if (word_valid && word_ready) word_valid_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt     = S_WARMUP;
               warm_left_nxt = WARM_LOAD;
            end
         end
         S_WARMUP: begin
            if (!enable) begin
               state_nxt      = S_IDLE;
               word_valid_nxt = 1'b0;
            end else if (consume) begin
               if (warm_left == '0) begin
                  // run counter 0 and window counter 0 mark "next sample starts fresh"
                  state_nxt    = S_COLLECT;
                  bit_left_nxt = BIT_LOAD;
                  shreg_nxt    = '0;
                  rct_run_nxt  = '0;
                  apt_left_nxt = '0;
               end else begin
                  warm_left_nxt = warm_left - WU_W'(1);
               end
            end
         end
         S_COLLECT: begin
            if (consume) begin
               rct_last_nxt = raw_bit;
               if (rct_run == '0 || raw_bit != rct_last) rct_run_nxt = RC_W'(1);
               else                                      rct_run_nxt = rct_run + RC_W'(1);

               if (apt_left == '0) begin
                  apt_ref_nxt  = raw_bit;
                  apt_cnt_nxt  = AP_W'(1);
                  apt_left_nxt = WIN_LOAD;
               end else begin
                  apt_cnt_nxt  = apt_cnt + AP_W'(raw_bit == apt_ref);
                  apt_left_nxt = apt_left - AP_W'(1);
               end

               fail = (rct_run_nxt == RC_W'(RCT_CUTOFF)) ||
                      (apt_cnt_nxt == AP_W'(APT_CUTOFF));
            end

            if (fail) begin
               state_nxt       = S_FAIL;
               health_fail_nxt = 1'b1;
               word_valid_nxt  = 1'b0;
               shreg_nxt       = '0;
            end else if (!enable) begin
               state_nxt      = S_IDLE;
               word_valid_nxt = 1'b0;
            end else if (consume) begin
               shreg_nxt = word_new;
               if (bit_left == '0) begin
                  bit_left_nxt = BIT_LOAD;
                  // a held, unaccepted word wins; the new one is dropped
                  if (!word_valid || word_ready) begin
                     word_out_nxt   = word_new;
                     word_valid_nxt = 1'b1;
                  end
               end else begin
                  bit_left_nxt = bit_left - BC_W'(1);
               end
            end
         end
         S_FAIL: begin
            if (clear_fail) begin
               state_nxt       = S_IDLE;
               health_fail_nxt = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         osc_en      <= 1'b0;
         dff_en      <= 1'b0;
         smp_v       <= 1'b0;
         warm_left   <= '0;
         bit_left    <= '0;
         shreg       <= '0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         health_fail <= 1'b0;
         rct_last    <= 1'b0;
         rct_run     <= '0;
         apt_ref     <= 1'b0;
         apt_cnt     <= '0;
         apt_left    <= '0;
      end else begin
         osc_en      <= (state_nxt == S_WARMUP) || (state_nxt == S_COLLECT);
         dff_en      <= (state_nxt == S_WARMUP) || (state_nxt == S_COLLECT);
         // oscillator output flop adds one cycle after dff_en
         smp_v       <= dff_en;
         warm_left   <= warm_left_nxt;
         bit_left    <= bit_left_nxt;
         shreg       <= shreg_nxt;
         word_out    <= word_out_nxt;
         word_valid  <= word_valid_nxt;
         health_fail <= health_fail_nxt;
         rct_last    <= rct_last_nxt;
         rct_run     <= rct_run_nxt;
         apt_ref     <= apt_ref_nxt;
         apt_cnt     <= apt_cnt_nxt;
         apt_left    <= apt_left_nxt;
      end
   end

endmodule

// File: tb/tb_trng_sample_collector.sv
// Testbench for trng_sample_collector: reset, packing table, RCT/APT failures,
// APT window restart, backpressure, abort/re-warmup, randomized streams and
// mid-operation reset, all checked cycle by cycle against a sample-level model.

module tb_trng_sample_collector;

   localparam int WARM       = 256;
   localparam int RCT_CUTOFF = 32;
   localparam int APT_WINDOW = 512;
   localparam int APT_CUTOFF = 410;

   logic        clk = 1'b0;
   logic        rst_n, enable, raw_bit, word_ready, clear_fail;
   logic        osc_en, dff_en, word_valid, health_fail;
   logic [63:0] word_out;

   int total = 0;
   int bad   = 0;

   bit          warm_bits [0:WARM-1];
   bit          col_bits  [0:2047];
   bit          rdy_sched [0:4095];
   logic [63:0] dut_got   [$];

   typedef struct {
      logic [3:0]  pat;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl [0:5];

   trng_sample_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .raw_bit     (raw_bit),
      .osc_en      (osc_en),
      .dff_en      (dff_en),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .health_fail (health_fail),
      .clear_fail  (clear_fail)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic bit sample_at(input int k);
      if (k < 0)    return 1'b0;
      if (k < WARM) return warm_bits[k];
      return col_bits[k-WARM];
   endfunction

   function automatic logic [63:0] pack(input int n);
      logic [63:0] w;
      for (int i = 0; i < 64; i++) w[i] = col_bits[64*n+i];
      return w;
   endfunction

   function automatic logic [63:0] cnt_word(input int n);
      return {56'h5A5A_5A5A_5A5A_5A, 8'(n+1)};
   endfunction

   // index of the collect sample that trips a health test, or -1
   function automatic int first_fail(input int ncol);
      int run, cnt;
      bit prev, ref_b;
      run = 0; cnt = 0; prev = 1'b0; ref_b = 1'b0;
      for (int j = 0; j < ncol; j++) begin
         if (j == 0 || col_bits[j] != prev) run = 1;
         else                               run++;
         prev = col_bits[j];
         if (j % APT_WINDOW == 0) begin
            ref_b = col_bits[j];
            cnt   = 1;
         end else if (col_bits[j] == ref_b) begin
            cnt++;
         end
         if (run >= RCT_CUTOFF || cnt >= APT_CUTOFF) return j;
      end
      return -1;
   endfunction

   task automatic tick_idle(input string tag);
      @(posedge clk); #1;
      check1({tag, ":idle_osc"},   osc_en,     1'b0);
      check1({tag, ":idle_dff"},   dff_en,     1'b0);
      check1({tag, ":idle_valid"}, word_valid, 1'b0);
   endtask

   task automatic clear_fail_seq(input string tag);
      clear_fail = 1'b1;
      @(posedge clk); #1;
      check1({tag, ":clr_health"}, health_fail, 1'b0);
      check1({tag, ":clr_osc"},    osc_en,      1'b0);
      clear_fail = 1'b0;
      tick_idle(tag);
   endtask

   // Enable from IDLE, stream WARM random warm-up bits then col_bits[0..ncol-1],
   // ready per edge from rdy_sched; enable drops at the edge that would consume
   // collect sample ncol. Stops early on the modelled health failure.
   task automatic run_stream(input int ncol, input string tag);
      int fidx, k, j;
      bit pend, fin, rd;
      logic [63:0] ew;
      fidx = first_fail(ncol);
      for (int i = 0; i < WARM; i++) warm_bits[i] = 1'($urandom_range(0, 1));
      pend = 1'b0; fin = 1'b0; ew = '0;
      dut_got.delete();
      enable     = 1'b1;
      word_ready = rdy_sched[0];
      raw_bit    = 1'($urandom_range(0, 1));
      for (int m = 0; !fin; m++) begin
         if (word_valid && word_ready) dut_got.push_back(word_out);
         rd = word_ready;
         @(posedge clk); #1;
         k = m - 2;
         j = k - WARM;
         if (j == ncol) begin
            fin  = 1'b1;
            pend = 1'b0;
            check1({tag, ":abort_osc"},    osc_en,      1'b0);
            check1({tag, ":abort_dff"},    dff_en,      1'b0);
            check1({tag, ":abort_valid"},  word_valid,  1'b0);
            check1({tag, ":abort_health"}, health_fail, 1'b0);
         end else if (j >= 0 && j == fidx) begin
            fin  = 1'b1;
            pend = 1'b0;
            check1({tag, ":fail_health"}, health_fail, 1'b1);
            check1({tag, ":fail_osc"},    osc_en,      1'b0);
            check1({tag, ":fail_dff"},    dff_en,      1'b0);
            check1({tag, ":fail_valid"},  word_valid,  1'b0);
         end else begin
            if (j >= 0 && j % 64 == 63) begin
               if (!pend || rd) begin
                  pend = 1'b1;
                  ew   = pack(j / 64);
               end
            end else if (pend && rd) begin
               pend = 1'b0;
            end
            check1({tag, ":osc"},    osc_en,      1'b1);
            check1({tag, ":dff"},    dff_en,      1'b1);
            check1({tag, ":health"}, health_fail, 1'b0);
            check1({tag, ":valid"},  word_valid,  pend);
            if (pend) check64({tag, ":word"}, word_out, ew);
         end
         if (!fin) begin
            word_ready = rdy_sched[m+1];
            if (m + 1 - 2 - WARM == ncol) begin
               enable  = 1'b0;
               raw_bit = ~sample_at(m - 2);
            end else begin
               raw_bit = sample_at(m - 1);
            end
         end
      end
      enable     = 1'b0;
      word_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ncol, p;
      logic [63:0] w;

      tbl[0] = '{4'b0101, 64'h5555_5555_5555_5555};
      tbl[1] = '{4'b1010, 64'hAAAA_AAAA_AAAA_AAAA};
      tbl[2] = '{4'b0011, 64'h3333_3333_3333_3333};
      tbl[3] = '{4'b1100, 64'hCCCC_CCCC_CCCC_CCCC};
      tbl[4] = '{4'b0111, 64'h7777_7777_7777_7777};
      tbl[5] = '{4'b1000, 64'h8888_8888_8888_8888};

      rst_n = 1'b0; enable = 1'b1; raw_bit = 1'b0; word_ready = 1'b0; clear_fail = 1'b0;

      // reset held with enable high
      repeat (3) begin
         @(posedge clk); #1;
         check1("rst_osc",    osc_en,      1'b0);
         check1("rst_dff",    dff_en,      1'b0);
         check1("rst_valid",  word_valid,  1'b0);
         check1("rst_health", health_fail, 1'b0);
         check64("rst_word",  word_out,    64'h0);
      end
      enable = 1'b0;
      rst_n  = 1'b1;
      repeat (3) tick_idle("post_rst");

      // packing table
      for (int e = 0; e < 6; e++) begin
         for (int j = 0; j < 192; j++) col_bits[j] = tbl[e].pat[j % 4];
         for (int m = 0; m < 4096; m++) rdy_sched[m] = 1'b1;
         run_stream(192, "pack");
         check_int("pack_count", dut_got.size(), 3);
         for (int i = 0; i < dut_got.size(); i++) check64("pack_word", dut_got[i], tbl[e].exp);
         tick_idle("pack");
      end

      // RCT: constant 1, then FAIL ignores enable, then clear
      for (int j = 0; j < 64; j++) col_bits[j] = 1'b1;
      for (int m = 0; m < 4096; m++) rdy_sched[m] = 1'b1;
      run_stream(64, "rct");
      check_int("rct_no_words", dut_got.size(), 0);
      enable = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check1("rct_hold_health", health_fail, 1'b1);
         check1("rct_hold_osc",    osc_en,      1'b0);
      end
      enable = 1'b0;
      clear_fail_seq("rct");

      // APT: 1111111 0 repeating, fails at collect sample 467
      for (int j = 0; j < 600; j++) col_bits[j] = (j % 8 != 7);
      run_stream(600, "apt");
      check_int("apt_fail_words", dut_got.size(), 7);
      clear_fail_seq("apt");

      // APT window restart: 406 matches in window 0, failure only in window 1
      for (int j = 0; j < 1000; j++) begin
         if (j < 400)      col_bits[j] = (j % 8 != 7);
         else if (j < 512) col_bits[j] = (j % 2 == 0);
         else              col_bits[j] = ((j - 512) % 8 != 7);
      end
      run_stream(1000, "aptwin");
      clear_fail_seq("aptwin");

      // backpressure: ready low for the first 150 collect samples
      for (int j = 0; j < 256; j++) begin
         w = cnt_word(j / 64);
         col_bits[j] = w[j % 64];
      end
      for (int m = 0; m < 4096; m++) rdy_sched[m] = (m >= 2 + WARM + 150);
      run_stream(256, "bp");
      check_int("bp_count", dut_got.size(), 3);
      if (dut_got.size() >= 2) begin
         check64("bp_first",  dut_got[0], cnt_word(0));
         check64("bp_second", dut_got[1], cnt_word(2));
      end
      tick_idle("bp");

      // abort at sample 30 of word 1, then re-enable with a full warm-up
      for (int m = 0; m < 4096; m++) rdy_sched[m] = 1'b1;
      for (int j = 0; j < 94; j++) col_bits[j] = 1'($urandom_range(0, 1));
      run_stream(94, "abort");
      check_int("abort_count", dut_got.size(), 1);
      tick_idle("abort");
      for (int j = 0; j < 128; j++) col_bits[j] = 1'($urandom_range(0, 1));
      run_stream(128, "rewarm");
      check_int("rewarm_count", dut_got.size(), 2);
      if (dut_got.size() >= 1) check64("rewarm_first", dut_got[0], pack(0));
      tick_idle("rewarm");

      // randomized streams with random backpressure and injected runs
      for (int it = 0; it < 4; it++) begin
         ncol = $urandom_range(150, 400);
         for (int j = 0; j < ncol; j++) col_bits[j] = 1'($urandom_range(0, 1));
         p = $urandom_range(5, 100);
         if (it == 2) for (int q = 0; q < 40; q++) col_bits[p+q] = 1'b1;
         if (it == 3) for (int q = 0; q < 40; q++) col_bits[p+q] = 1'b0;
         for (int m = 0; m < 4096; m++) rdy_sched[m] = ($urandom_range(0, 3) != 0);
         run_stream(ncol, "rand");
         clear_fail_seq("rand");
      end

      // reset in the middle of COLLECT
      enable = 1'b1; word_ready = 1'b0;
      repeat (400) begin
         raw_bit = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      check1("mid_valid_before", word_valid, 1'b1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check1("mid_rst_osc",    osc_en,      1'b0);
      check1("mid_rst_dff",    dff_en,      1'b0);
      check1("mid_rst_valid",  word_valid,  1'b0);
      check1("mid_rst_health", health_fail, 1'b0);
      check64("mid_rst_word",  word_out,    64'h0);
      rst_n  = 1'b1;
      enable = 1'b0;
      tick_idle("mid_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trng_sample_collector.md
# trng_sample_collector

Downstream consumer of the FiRO3 ring-oscillator entropy source. It drives the oscillator's `en`/`dff_en`, takes the sampled `random_out` bit stream, and runs continuous health tests on it: a repetition-count test and an adaptive-proportion test. It packs the bits into 64-bit words and hands them to the SHA3 conditioning stage over a valid/ready handshake.

## Interface
- `WORD_W`, 64: bits per output word (one SHA3 lane).
- `WARMUP`, 256: samples discarded after each start.
- `RCT_CUTOFF`, 32: a run of identical samples of this length fails the repetition-count test.
- `APT_WINDOW`, 512: adaptive-proportion window length, in samples.
- `APT_CUTOFF`, 410: matches of the window reference bit that fail the adaptive-proportion test.
- `clk`, in, 1: single clock; every register is in this domain.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `enable`, in, 1: requests entropy collection.
- `raw_bit`, in, 1: connects to the oscillator `random_out`.
- `osc_en`, out, 1: drives the oscillator `en`.
- `dff_en`, out, 1: drives the oscillator `dff_en`.
- `word_out`, out, WORD_W: packed output word.
- `word_valid`, out, 1: `word_out` holds an unconsumed word.
- `word_ready`, in, 1: the conditioner accepts the word.
- `health_fail`, out, 1: sticky health-test failure flag.
- `clear_fail`, in, 1: clears the failure and returns the block to IDLE.

## Operation
- States: IDLE, WARMUP, COLLECT, FAIL.
- Reset values: state IDLE. `osc_en`, `dff_en`, `word_valid` and `health_fail` are 0. `word_out` is 0. All counters are 0.
- All outputs are registered.
- `osc_en` and `dff_en` are 1 in WARMUP and COLLECT, and 0 in IDLE and FAIL.
- Sample qualifier `smp_v` is `dff_en` delayed by one cycle, which matches the oscillator's internal flop.
- `raw_bit` is consumed only when `smp_v`=1 and the state is WARMUP or COLLECT. Samples in flight after leaving those states are ignored.
- IDLE -> WARMUP on `enable`=1.
- WARMUP: the first WARMUP consumed samples are discarded and no tests run. The state moves to COLLECT in the cycle the WARMUP-th sample is consumed.
- COLLECT: every consumed sample does three things:
  - shifts in LSB-first, so bit i of the word is the i-th sample;
  - feeds the repetition-count test (RCT);
  - feeds the adaptive-proportion test (APT).
- Word completion: after WORD_W samples the word moves to `word_out` and `word_valid` is set.
  - If `word_valid`=1 and `word_ready`=0 at completion, the new word is dropped and the held word is kept.
  - If completion coincides with a handshake (`word_valid` & `word_ready`), the new word loads and `word_valid` stays 1.
  - A handshake with no completion clears `word_valid`.
- RCT:
  - Keeps the last sample and a run counter.
  - The run counter resets to 1 on a differing sample and to 1 on the first sample of COLLECT.
  - The run reaching RCT_CUTOFF is a failure.
- APT:
  - The first sample of each window is the reference bit, and the match count starts at 1.
  - Each later sample equal to the reference adds 1.
  - The count reaching APT_CUTOFF is a failure.
  - After APT_WINDOW samples a new window starts with the next sample.
  - Windows restart on entry to COLLECT.
- Failure, from either test:
  - state -> FAIL and `health_fail` -> 1;
  - the partial word is discarded and `word_valid` -> 0;
  - the failing sample is never output.
- FAIL is left only by `clear_fail`=1, which goes to IDLE with `health_fail` -> 0. `enable` is ignored in FAIL.
- `enable`=0 in WARMUP or COLLECT:
  - state -> IDLE;
  - the partial word and test counters are discarded;
  - `word_valid` -> 0.
  - A later `enable` repeats the full WARMUP.
- `rst_n`=0 mid-operation restores all reset values at the next edge, regardless of state.
- Precedence: `rst_n`, then health failure, then `enable`=0, then the normal transitions.

## Timing
- Cycle 0: `enable` sampled high in IDLE. Cycle 1: `osc_en` and `dff_en` are 1. Cycle 2: first sample consumed.
- In steady COLLECT, one sample is consumed per cycle.
- `word_valid` rises the cycle after the WORD_W-th sample of a word is consumed. The word period is WORD_W cycles.
- `health_fail`=1 and `osc_en`=`dff_en`=0 the cycle after the failing sample is consumed.
- `enable`=0 in cycle N gives IDLE with `osc_en`=0 in cycle N+1.
- Handshake: `word_out` is stable while `word_valid`=1 and `word_ready`=0.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `enable`=1. Required: all outputs 0, and IDLE after release until `enable` is sampled.
- Packing: with `enable`=1 and `word_ready`=1, drive 256 warmup samples and then alternating 1,0,… Required:
  - `word_out`=0x5555_5555_5555_5555 with `word_valid` high for 1 cycle;
  - `word_valid` rises 64 cycles after the first COLLECT sample is consumed;
  - every word identical thereafter;
  - no failure.
- RCT: in COLLECT drive constant 1. Required: `health_fail`=1 the cycle after the 32nd sample, `word_valid` never set, and `osc_en`=0. Then `clear_fail`=1 gives IDLE with `health_fail`=0.
- APT: in COLLECT drive the repeating pattern 1111111 0, so runs of 7 stay under RCT. Required: failure at the 410th match of the reference 1, within the first window.
- Backpressure: in COLLECT with `word_ready`=0 for 150 cycles, drive a counting bit pattern. Required:
  - the first word is held stable;
  - the second word is dropped;
  - `word_ready`=1 accepts the first word;
  - the next delivered word is the third.
- Abort: drop `enable` at sample 30 of a word. Required: IDLE and `osc_en`=0 next cycle. Re-enabling repeats the 256-sample warmup, and the first word contains only post-warmup samples.
